util_sequences_inserter: RTL and testbench

UTIL_SEQUENCES_INSERTER -- requirements
Module: util_sequences_inserter

---
 rtl/util_sequences_inserter_pkg.sv | 14 +
 rtl/util_sequences_inserter.sv | 147 ++++++++++++++
 tb/tb_util_sequences_inserter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/util_sequences_inserter_pkg.sv
// rtl/util_sequences_inserter_pkg.sv - shared state encodings and helpers for the sequence utilities
package util_sequences_inserter_pkg;

  // Framing FSM encodings, shared by the inserter, the detector and their benches
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SEQ     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;

  // Counter width for a modulo-n index; a count of 1 still needs a 1-bit register
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/util_sequences_inserter.sv
// rtl/util_sequences_inserter.sv - prepends a fixed sync sequence to every FRAME_LEN-beat payload frame
module util_sequences_inserter
  import util_sequences_inserter_pkg::*;
#(
  parameter int TDATA_WIDTH   = 8,
  parameter int SEQUENCES_LEN = 4,
  parameter logic [TDATA_WIDTH*SEQUENCES_LEN-1:0] SEQUENCES_PACK = '0,
  parameter int FRAME_LEN     = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   en,
  input  logic                   s_axis_tvalid,
  input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
  output logic                   s_axis_tready,
  output logic                   m_axis_tvalid,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic [31:0]            frame_cnt,
  output logic                   busy
);

  localparam int SEQ_W = idx_width(SEQUENCES_LEN);
  localparam int PAY_W = idx_width(FRAME_LEN);
  localparam logic [SEQ_W-1:0] SEQ_LAST = SEQ_W'(SEQUENCES_LEN - 1);
  localparam logic [PAY_W-1:0] PAY_LAST = PAY_W'(FRAME_LEN - 1);

  logic [1:0]             state_q, state_d;
  logic [SEQ_W-1:0]       seq_idx_q, seq_idx_d;
  logic [PAY_W-1:0]       pay_idx_q, pay_idx_d;
  logic                   m_tvalid_q, m_tvalid_d;
  logic [TDATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic                   m_tlast_q, m_tlast_d;
  logic [31:0]            frame_cnt_q, frame_cnt_d;

  logic                   load;
  logic [TDATA_WIDTH-1:0] seq_elems [SEQUENCES_LEN];
  logic [TDATA_WIDTH-1:0] seq_elem;

  // Unpack the sequence parameter; element 0 sits in the least significant slice
  for (genvar g = 0; g < SEQUENCES_LEN; g++) begin : g_unpack
    assign seq_elems[g] = SEQUENCES_PACK[g*TDATA_WIDTH +: TDATA_WIDTH];
  end

  // The output register may take a new beat when it is empty or being drained
  assign load          = en && (!m_tvalid_q || m_axis_tready);
  assign s_axis_tready = (state_q == ST_PAYLOAD) && load;

  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tlast  = m_tlast_q;
  assign frame_cnt     = frame_cnt_q;
  assign busy          = (state_q != ST_IDLE);

  // Sequence element selected by seq_idx, written as a compare-mux so any length indexes safely
  always_comb begin
    seq_elem = '0;
    for (int i = 0; i < SEQUENCES_LEN; i++) begin
      if (seq_idx_q == SEQ_W'(i)) seq_elem = seq_elems[i];
    end
  end

  // Framing FSM next state and output register load
  always_comb begin
    state_d     = state_q;
    seq_idx_d   = seq_idx_q;
    pay_idx_d   = pay_idx_q;
    m_tvalid_d  = m_tvalid_q;
    m_tdata_d   = m_tdata_q;
    m_tlast_d   = m_tlast_q;
    frame_cnt_d = frame_cnt_q;

    if (!en) begin
      // Abandon any partial frame; the next enable restarts at sequence element 0
      state_d    = ST_IDLE;
      seq_idx_d  = '0;
      pay_idx_d  = '0;
      m_tvalid_d = 1'b0;
      m_tlast_d  = 1'b0;
    end else begin
      if (m_tvalid_q && m_axis_tready && m_tlast_q) frame_cnt_d = frame_cnt_q + 32'd1;

      case (state_q)
        ST_IDLE: begin
          state_d = ST_SEQ;
        end
        ST_SEQ: begin
          if (load) begin
            m_tdata_d  = seq_elem;
            m_tvalid_d = 1'b1;
            m_tlast_d  = 1'b0;
            if (seq_idx_q == SEQ_LAST) begin
              seq_idx_d = '0;
              state_d   = ST_PAYLOAD;
            end else begin
              seq_idx_d = seq_idx_q + 1'b1;
            end
          end
        end
        ST_PAYLOAD: begin
          if (load) begin
            if (s_axis_tvalid) begin
              m_tdata_d  = s_axis_tdata;
              m_tvalid_d = 1'b1;
              m_tlast_d  = (pay_idx_q == PAY_LAST);
              if (pay_idx_q == PAY_LAST) begin
                pay_idx_d = '0;
                state_d   = ST_SEQ;
              end else begin
                pay_idx_d = pay_idx_q + 1'b1;
              end
            end else begin
              // Source starved: emit a bubble rather than repeat the previous beat
              m_tvalid_d = 1'b0;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      seq_idx_q   <= '0;
      pay_idx_q   <= '0;
      m_tvalid_q  <= 1'b0;
      m_tdata_q   <= '0;
      m_tlast_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      seq_idx_q   <= seq_idx_d;
      pay_idx_q   <= pay_idx_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tdata_q   <= m_tdata_d;
      m_tlast_q   <= m_tlast_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_util_sequences_inserter.sv
// tb/tb_util_sequences_inserter.sv - directed self-checking bench for util_sequences_inserter
module tb_util_sequences_inserter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;

  // Instance 1: default lengths, sequence AA BB CC DD
  logic        en1, s1_tvalid, s1_tready, m1_tvalid, m1_tready, m1_tlast, busy1;
  logic [7:0]  s1_tdata, m1_tdata;
  logic [31:0] fcnt1;

  // Instance 2: one-beat sequence (5A), one-beat frames
  logic        en2, s2_tvalid, s2_tready, m2_tvalid, m2_tready, m2_tlast, busy2;
  logic [7:0]  s2_tdata, m2_tdata;
  logic [31:0] fcnt2;

  util_sequences_inserter #(
    .TDATA_WIDTH(8), .SEQUENCES_LEN(4),
    .SEQUENCES_PACK({8'hDD, 8'hCC, 8'hBB, 8'hAA}), .FRAME_LEN(16)
  ) dut1 (
    .clk(clk), .rstn(rstn), .en(en1),
    .s_axis_tvalid(s1_tvalid), .s_axis_tdata(s1_tdata), .s_axis_tready(s1_tready),
    .m_axis_tvalid(m1_tvalid), .m_axis_tdata(m1_tdata), .m_axis_tready(m1_tready),
    .m_axis_tlast(m1_tlast), .frame_cnt(fcnt1), .busy(busy1)
  );

  util_sequences_inserter #(
    .TDATA_WIDTH(8), .SEQUENCES_LEN(1),
    .SEQUENCES_PACK(8'h5A), .FRAME_LEN(1)
  ) dut2 (
    .clk(clk), .rstn(rstn), .en(en2),
    .s_axis_tvalid(s2_tvalid), .s_axis_tdata(s2_tdata), .s_axis_tready(s2_tready),
    .m_axis_tvalid(m2_tvalid), .m_axis_tdata(m2_tdata), .m_axis_tready(m2_tready),
    .m_axis_tlast(m2_tlast), .frame_cnt(fcnt2), .busy(busy2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int unsigned src1, src2;
  logic        fire1, fire2;
  logic        rand_ready;
  logic        gap_en;
  int          gap_left;
  logic        stall_prev;
  logic [8:0]  prev_beat;
  logic        seen_valid;
  int          idle_cnt;
  logic [8:0]  out1[$];
  logic [8:0]  out2[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected {tlast, tdata} of accepted beat i of instance 1, counted from a fresh start
  function automatic logic [8:0] exp1(input int i);
    int pos;
    pos = i % 20;
    if (pos < 4) return {1'b0, 8'(8'hAA + pos * 8'h11)};
    return {(pos == 19), 8'((i / 20) * 16 + pos - 4)};
  endfunction

  // Expected {tlast, tdata} of accepted beat i of instance 2
  function automatic logic [8:0] exp2(input int i);
    if (i % 2 == 0) return {1'b0, 8'h5A};
    return {1'b1, 8'(i / 2)};
  endfunction

  // One clock: drive inputs just after the edge, sample everything on the falling edge
  task automatic cycle();
    @(posedge clk);
    #1;
    if (fire1) src1++;
    if (fire2) src2++;
    fire1 = 1'b0;
    fire2 = 1'b0;
    s1_tdata = src1[7:0];
    s2_tdata = src2[7:0];
    if (gap_en && src1 == 6 && gap_left > 0) begin
      s1_tvalid = 1'b0;
      gap_left--;
    end else begin
      s1_tvalid = 1'b1;
    end
    m1_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    if (stall_prev) begin
      chk("stall_valid", 32'(m1_tvalid), 32'd1);
      chk("stall_beat", 32'({m1_tlast, m1_tdata}), 32'(prev_beat));
    end
    stall_prev = m1_tvalid && !m1_tready;
    prev_beat  = {m1_tlast, m1_tdata};
    if (seen_valid && !m1_tvalid) idle_cnt++;
    if (m1_tvalid) seen_valid = 1'b1;
    if (m1_tvalid && m1_tready) out1.push_back({m1_tlast, m1_tdata});
    if (m2_tvalid && m2_tready) out2.push_back({m2_tlast, m2_tdata});
    fire1 = s1_tvalid && s1_tready;
    fire2 = s2_tvalid && s2_tready;
  endtask

  task automatic clear_bench();
    src1 = 0; src2 = 0; fire1 = 1'b0; fire2 = 1'b0;
    stall_prev = 1'b0; seen_valid = 1'b0; idle_cnt = 0;
    out1.delete(); out2.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn = 1'b0; en1 = 1'b0; en2 = 1'b0;
    rand_ready = 1'b0; gap_en = 1'b0; gap_left = 0;
    m1_tready = 1'b1; s1_tvalid = 1'b1;
    clear_bench();
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic run_collect(input int which, input int n, input int budget);
    int c;
    c = 0;
    while (((which == 1) ? out1.size() : out2.size()) < n && c < budget) begin
      cycle();
      c++;
    end
    chk("collect_count", 32'((which == 1) ? out1.size() : out2.size()), 32'(n));
  endtask

  task automatic check_stream1(input string tag, input int n);
    for (int i = 0; i < n && i < out1.size(); i++) chk(tag, 32'(out1[i]), 32'(exp1(i)));
  endtask

  initial begin
    rstn = 1'b0; en1 = 1'b0; en2 = 1'b0;
    s1_tvalid = 1'b1; s1_tdata = 8'h00; m1_tready = 1'b1;
    s2_tvalid = 1'b1; s2_tdata = 8'h00; m2_tready = 1'b1;
    rand_ready = 1'b0; gap_en = 1'b0; gap_left = 0; prev_beat = '0;
    clear_bench();

    // Reset state
    @(posedge clk);
    #1;
    chk("rst_tvalid", 32'(m1_tvalid), 32'd0);
    chk("rst_tdata", 32'(m1_tdata), 32'd0);
    chk("rst_tlast", 32'(m1_tlast), 32'd0);
    chk("rst_fcnt", fcnt1, 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_sready", 32'(s1_tready), 32'd0);

    // Continuous flow: AA BB CC DD 00..0F (tlast on 0F), then AA
    do_reset();
    en1 = 1'b1;
    run_collect(1, 21, 100);
    check_stream1("cont_beat", 21);
    chk("cont_fcnt", fcnt1, 32'd1);
    chk("cont_no_bubble", 32'(idle_cnt), 32'd0);

    // Random downstream backpressure: two full frames plus the next AA, in order
    do_reset();
    en1 = 1'b1;
    rand_ready = 1'b1;
    run_collect(1, 41, 600);
    check_stream1("bp_beat", 41);
    chk("bp_fcnt", fcnt1, 32'd2);
    rand_ready = 1'b0;

    // Source gap of 3 cycles after payload beat 05
    do_reset();
    en1 = 1'b1;
    gap_en = 1'b1;
    gap_left = 3;
    run_collect(1, 21, 100);
    check_stream1("gap_beat", 21);
    chk("gap_bubbles", 32'(idle_cnt), 32'd3);
    gap_en = 1'b0;

    // Disable mid-frame: partial frame dropped, frame count held, restart at AA
    do_reset();
    en1 = 1'b1;
    run_collect(1, 30, 100);
    chk("dis_fcnt_before", fcnt1, 32'd1);
    @(posedge clk);
    #1;
    en1 = 1'b0;
    @(posedge clk);
    #1;
    chk("dis_tvalid", 32'(m1_tvalid), 32'd0);
    chk("dis_tlast", 32'(m1_tlast), 32'd0);
    chk("dis_busy", 32'(busy1), 32'd0);
    chk("dis_sready", 32'(s1_tready), 32'd0);
    @(posedge clk);
    #1;
    chk("dis_fcnt_held", fcnt1, 32'd1);
    clear_bench();
    en1 = 1'b1;
    run_collect(1, 5, 50);
    check_stream1("reen_beat", 5);

    // Asynchronous reset mid-sequence after BB
    do_reset();
    en1 = 1'b1;
    run_collect(1, 2, 50);
    check_stream1("ares_pre", 2);
    #1;
    rstn = 1'b0;
    #1;
    chk("ares_tvalid", 32'(m1_tvalid), 32'd0);
    chk("ares_tdata", 32'(m1_tdata), 32'd0);
    chk("ares_tlast", 32'(m1_tlast), 32'd0);
    chk("ares_busy", 32'(busy1), 32'd0);
    chk("ares_sready", 32'(s1_tready), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    clear_bench();
    run_collect(1, 1, 50);
    check_stream1("ares_restart", 1);
    chk("ares_fcnt", fcnt1, 32'd0);

    // One-beat sequence and one-beat frames: 5A / payload with tlast alternating
    do_reset();
    en2 = 1'b1;
    run_collect(2, 6, 50);
    for (int i = 0; i < 6 && i < out2.size(); i++) chk("f1_beat", 32'(out2[i]), 32'(exp2(i)));
    chk("f1_fcnt", fcnt2, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
